// File: rtl/sprite_pkg.sv
// Shared types for the SPI sprite register file: opcodes,
// command FSM states and a bit-order helper for bitmap bytes.
package sprite_pkg;

  typedef enum logic [1:0] {
    OP_POS,
    OP_COLOR,
    OP_BITMAP,
    OP_ENABLE
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CMD,
    S_DATA,
    S_DONE
  } state_t;

  localparam int POS_BYTES = 4;

  // Byte MSB is the lowest pixel index, so bit 7 lands on bit 0.
  function automatic logic [7:0] rev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

endpackage

// File: rtl/spi_byte_rx.sv
// SPI mode-0 byte receiver: syncs spi_clk/data/cs_n into clk,
// shifts MSB first, pulses byte_valid per 8 bits; cs_active = synced cs low.
module spi_byte_rx (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       spi_clk,
  input  logic       spi_data,
  input  logic       spi_cs_n,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       cs_active
);

  logic [1:0] clk_s;
  logic [1:0] dat_s;
  logic [1:0] cs_s;
  logic       clk_d;
  logic [6:0] shift;
  logic [2:0] cnt;
  logic       rise;

  assign rise      = clk_s[1] & ~clk_d;
  assign cs_active = ~cs_s[1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_s      <= '0;
      dat_s      <= '0;
      cs_s       <= 2'b11;
      clk_d      <= 1'b0;
      shift      <= '0;
      cnt        <= '0;
      byte_valid <= 1'b0;
      byte_data  <= '0;
    end else begin
      clk_s      <= {clk_s[0], spi_clk};
      dat_s      <= {dat_s[0], spi_data};
      cs_s       <= {cs_s[0], spi_cs_n};
      clk_d      <= clk_s[1];
      byte_valid <= 1'b0;
      // Deselect drops any partial byte.
      if (cs_s[1]) begin
        cnt   <= '0;
        shift <= '0;
      end else if (rise) begin
        shift <= {shift[5:0], dat_s[1]};
        cnt   <= cnt + 3'd1;
        if (cnt == 3'd7) begin
          byte_valid <= 1'b1;
          byte_data  <= {shift, dat_s[1]};
        end
      end
    end
  end

endmodule

// File: rtl/spi_sprite_regfile.sv
// SPI-programmed sprite register file: command FSM writes shadow banks,
// active banks copy the shadow at frame boundaries once SPI is idle.
module spi_sprite_regfile
  import sprite_pkg::*;
#(
  parameter int NUM_SPRITES = 4,
  parameter int SPRITE_W    = 16,
  parameter int SPRITE_H    = 16,
  parameter int COORD_W     = 10,
  parameter int COLOR_W     = 6
) (
  input  logic                                  clk,
  input  logic                                  reset_n,
  input  logic                                  spi_clk,
  input  logic                                  spi_data,
  input  logic                                  spi_cs_n,
  input  logic                                  next_frame,
  output logic [NUM_SPRITES*COORD_W-1:0]        sprite_x,
  output logic [NUM_SPRITES*COORD_W-1:0]        sprite_y,
  output logic [NUM_SPRITES*COLOR_W-1:0]        sprite_color,
  output logic [NUM_SPRITES-1:0]                sprite_en,
  output logic [NUM_SPRITES*SPRITE_W*SPRITE_H-1:0] sprite_bitmap,
  output logic                                  busy,
  output logic                                  err
);

  localparam int BMP_BITS  = SPRITE_W * SPRITE_H;
  localparam int BMP_BYTES = BMP_BITS / 8;
  localparam int CNT_MAX   =
    (BMP_BYTES > POS_BYTES) ? BMP_BYTES : POS_BYTES;
  localparam int CNT_W     = $clog2(CNT_MAX) + 1;

  logic       byte_valid;
  logic [7:0] byte_data;
  logic       cs_active;

  spi_byte_rx u_rx (
    .clk        (clk),
    .reset_n    (reset_n),
    .spi_clk    (spi_clk),
    .spi_data   (spi_data),
    .spi_cs_n   (spi_cs_n),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .cs_active  (cs_active)
  );

  assign busy = cs_active;

  state_t             state;
  op_t                op;
  logic [5:0]         idx;
  logic [CNT_W-1:0]   cnt;
  logic [COORD_W-1:0] x_acc;
  logic [COORD_W-1:0] y_acc;

  logic [NUM_SPRITES*COORD_W-1:0]  sh_x;
  logic [NUM_SPRITES*COORD_W-1:0]  sh_y;
  logic [NUM_SPRITES*COLOR_W-1:0]  sh_col;
  logic [NUM_SPRITES-1:0]          sh_en;
  logic [NUM_SPRITES*BMP_BITS-1:0] sh_bmp;

  logic pending;
  logic do_commit;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= S_IDLE;
      op     <= OP_POS;
      idx    <= '0;
      cnt    <= '0;
      x_acc  <= '0;
      y_acc  <= '0;
      sh_x   <= '0;
      sh_y   <= '0;
      sh_col <= '0;
      sh_en  <= '0;
      sh_bmp <= '0;
      err    <= 1'b0;
    end else begin
      err <= 1'b0;
      if (!cs_active) begin
        state <= S_IDLE;
        // Only a truncated POS is an error; bitmap keeps its bytes.
        if (state == S_DATA && op == OP_POS) err <= 1'b1;
      end else begin
        unique case (state)
          S_IDLE: state <= S_CMD;
          S_CMD: if (byte_valid) begin
            op  <= op_t'(byte_data[7:6]);
            idx <= byte_data[5:0];
            cnt <= '0;
            if (int'(byte_data[5:0]) >= NUM_SPRITES) begin
              err   <= 1'b1;
              state <= S_DONE;
            end else begin
              state <= S_DATA;
            end
          end
          S_DATA: if (byte_valid) begin
            cnt <= cnt + 1'b1;
            unique case (op)
              OP_POS: begin
                // Accumulators shift whole bytes in; only the
                // low COORD_W bits of each 16-bit word survive.
                if (cnt == CNT_W'(POS_BYTES - 1)) begin
                  sh_x[int'(idx)*COORD_W +: COORD_W] <= x_acc;
                  sh_y[int'(idx)*COORD_W +: COORD_W] <=
                    COORD_W'({y_acc, byte_data});
                  state <= S_DONE;
                end else if (cnt < CNT_W'(2)) begin
                  x_acc <= COORD_W'({x_acc, byte_data});
                end else begin
                  y_acc <= COORD_W'({y_acc, byte_data});
                end
              end
              OP_COLOR: begin
                sh_col[int'(idx)*COLOR_W +: COLOR_W] <=
                  COLOR_W'(byte_data);
                state <= S_DONE;
              end
              OP_BITMAP: begin
                sh_bmp[int'(idx)*BMP_BITS + 8*int'(cnt) +: 8] <=
                  rev8(byte_data);
                if (cnt == CNT_W'(BMP_BYTES - 1)) state <= S_DONE;
              end
              OP_ENABLE: begin
                sh_en[int'(idx) +: 1] <= byte_data[0];
                state <= S_DONE;
              end
            endcase
          end
          S_DONE: begin
          end
        endcase
      end
    end
  end

  // A frame request during a transaction waits for cs to rise,
  // so the renderer never sees a half-written sprite.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending       <= 1'b0;
      do_commit     <= 1'b0;
      sprite_x      <= '0;
      sprite_y      <= '0;
      sprite_color  <= '0;
      sprite_en     <= '0;
      sprite_bitmap <= '0;
    end else begin
      do_commit <= 1'b0;
      if (do_commit) begin
        sprite_x      <= sh_x;
        sprite_y      <= sh_y;
        sprite_color  <= sh_col;
        sprite_en     <= sh_en;
        sprite_bitmap <= sh_bmp;
      end
      if (next_frame || pending) begin
        if (busy) begin
          pending <= 1'b1;
        end else begin
          pending   <= 1'b0;
          do_commit <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_sprite_regfile.sv
// Self-checking bench for spi_sprite_regfile: directed and random
// SPI transactions against a byte-level shadow/active model.
module tb_spi_sprite_regfile;

  localparam int N  = 4;
  localparam int SW = 16;
  localparam int SH = 16;
  localparam int CW = 10;
  localparam int KW = 6;
  localparam int BB = SW * SH;
  localparam int NB = BB / 8;
  localparam int HP = 3;
  localparam int RW = 2*N*CW + N*KW + N;

  typedef logic [7:0] bq_t[$];

  logic clk = 1'b0;
  logic reset_n, spi_clk, spi_data, spi_cs_n, next_frame;
  logic [N*CW-1:0] sprite_x, sprite_y;
  logic [N*KW-1:0] sprite_color;
  logic [N-1:0]    sprite_en;
  logic [N*BB-1:0] sprite_bitmap;
  logic            busy, err;

  spi_sprite_regfile #(
    .NUM_SPRITES(N), .SPRITE_W(SW), .SPRITE_H(SH),
    .COORD_W(CW), .COLOR_W(KW)
  ) dut (
    .clk(clk), .reset_n(reset_n), .spi_clk(spi_clk),
    .spi_data(spi_data), .spi_cs_n(spi_cs_n),
    .next_frame(next_frame), .sprite_x(sprite_x),
    .sprite_y(sprite_y), .sprite_color(sprite_color),
    .sprite_en(sprite_en), .sprite_bitmap(sprite_bitmap),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int err_cnt = 0;

  always @(posedge clk) if (err === 1'b1) err_cnt++;

  logic [CW-1:0] sx[N], sy[N], ax[N], ay[N];
  logic [KW-1:0] sc[N], ac[N];
  logic          se[N], ae[N];
  logic [BB-1:0] sb[N], ab[N];

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      sx[i] = '0; sy[i] = '0; sc[i] = '0; se[i] = 1'b0; sb[i] = '0;
      ax[i] = '0; ay[i] = '0; ac[i] = '0; ae[i] = 1'b0; ab[i] = '0;
    end
  endtask

  task automatic model_commit();
    for (int i = 0; i < N; i++) begin
      ax[i] = sx[i]; ay[i] = sy[i]; ac[i] = sc[i];
      ae[i] = se[i]; ab[i] = sb[i];
    end
  endtask

  task automatic model_txn(input bq_t q, output int e);
    logic [1:0] op;
    int idx, nd;
    e = 0;
    op = q[0][7:6];
    idx = int'(q[0][5:0]);
    nd = q.size() - 1;
    if (idx >= N) begin
      e = 1;
      return;
    end
    case (op)
      2'd0: if (nd >= 4) begin
        sx[idx] = CW'({q[1], q[2]});
        sy[idx] = CW'({q[3], q[4]});
      end else e = 1;
      2'd1: if (nd >= 1) sc[idx] = q[1][KW-1:0];
      2'd2: for (int k = 0; k < nd && k < NB; k++)
        for (int j = 0; j < 8; j++) sb[idx][8*k+j] = q[1+k][7-j];
      default: if (nd >= 1) se[idx] = q[1][0];
    endcase
  endtask

  function automatic logic [RW-1:0] exp_regs();
    logic [N*CW-1:0] x, y;
    logic [N*KW-1:0] c;
    logic [N-1:0] e;
    for (int i = 0; i < N; i++) begin
      x[i*CW +: CW] = ax[i];
      y[i*CW +: CW] = ay[i];
      c[i*KW +: KW] = ac[i];
      e[i] = ae[i];
    end
    return {x, y, c, e};
  endfunction

  function automatic logic [N*BB-1:0] exp_bmp();
    logic [N*BB-1:0] b;
    for (int i = 0; i < N; i++) b[i*BB +: BB] = ab[i];
    return b;
  endfunction

  function automatic int first_bad_bmp();
    for (int i = 0; i < N; i++)
      if (sprite_bitmap[i*BB +: BB] !== ab[i]) return i;
    return 0;
  endfunction

  task automatic spi_bits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      spi_data = b[7-i];
      repeat (HP) @(negedge clk);
      spi_clk = 1'b1;
      repeat (HP) @(negedge clk);
      spi_clk = 1'b0;
    end
  endtask

  task automatic send_txn(input bq_t q, input int extra);
    @(negedge clk);
    spi_cs_n = 1'b0;
    repeat (4) @(negedge clk);
    foreach (q[i]) spi_bits(q[i], 8);
    if (extra > 0) spi_bits(8'($urandom), extra);
    repeat (4) @(negedge clk);
    spi_cs_n = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic frame_pulse();
    @(negedge clk);
    next_frame = 1'b1;
    @(negedge clk);
    next_frame = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({sprite_x, sprite_y, sprite_color, sprite_en} !== exp_regs()) begin
      failures++;
      $display("FAIL reset_regs got %h want %h",
        {sprite_x, sprite_y, sprite_color, sprite_en}, exp_regs());
    end
    checks++;
    if (sprite_bitmap !== exp_bmp()) begin
      failures++;
      $display("FAIL reset_bmp sprite %0d got %h want %h", first_bad_bmp(),
        sprite_bitmap[first_bad_bmp()*BB +: BB], ab[first_bad_bmp()]);
    end
    checks++;
    if ({busy, err} !== 2'b00) begin
      failures++;
      $display("FAIL reset_flags got %b want 00", {busy, err});
    end
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_pos();
    bq_t q = '{8'h01, 8'h01, 8'h23, 8'h00, 8'h45};
    int e, e0;
    logic [RW-1:0] old;
    e0 = err_cnt;
    model_txn(q, e);
    send_txn(q, 0);
    checks++;
    if (err_cnt - e0 !== e) begin
      failures++;
      $display("FAIL pos_err got %0d want %0d", err_cnt - e0, e);
    end
    old = exp_regs();
    frame_pulse();
    checks++;
    if ({sprite_x, sprite_y, sprite_color, sprite_en} !== old) begin
      failures++;
      $display("FAIL pos_early got %h want %h",
        {sprite_x, sprite_y, sprite_color, sprite_en}, old);
    end
    model_commit();
    @(posedge clk);
    #1;
    checks++;
    if ({sprite_x, sprite_y, sprite_color, sprite_en} !== exp_regs()) begin
      failures++;
      $display("FAIL pos_regs got %h want %h",
        {sprite_x, sprite_y, sprite_color, sprite_en}, exp_regs());
    end
    checks++;
    if ({sprite_x[CW +: CW], sprite_y[CW +: CW]} !== {10'h123, 10'h045}) begin
      failures++;
      $display("FAIL pos_xy1 got %h/%h want 123/045",
        sprite_x[CW +: CW], sprite_y[CW +: CW]);
    end
  endtask

  task automatic test_bitmap();
    bq_t q;
    int e, e0;
    logic [BB-1:0] want;
    q.push_back(8'h80);
    repeat (NB) q.push_back(8'hA5);
    repeat (2) q.push_back(8'hFF);
    want = {NB{8'hA5}};
    e0 = err_cnt;
    model_txn(q, e);
    send_txn(q, 0);
    checks++;
    if (err_cnt - e0 !== e) begin
      failures++;
      $display("FAIL bmp_err got %0d want %0d", err_cnt - e0, e);
    end
    frame_pulse();
    model_commit();
    @(posedge clk);
    #1;
    checks++;
    if (sprite_bitmap !== exp_bmp()) begin
      failures++;
      $display("FAIL bmp_all sprite %0d got %h want %h", first_bad_bmp(),
        sprite_bitmap[first_bad_bmp()*BB +: BB], ab[first_bad_bmp()]);
    end
    checks++;
    if (sprite_bitmap[0 +: BB] !== want) begin
      failures++;
      $display("FAIL bmp_a5 got %h want %h", sprite_bitmap[0 +: BB], want);
    end
  endtask

  task automatic test_bad_index();
    bq_t q = '{8'h3F, 8'h15};
    int e, e0;
    e0 = err_cnt;
    model_txn(q, e);
    send_txn(q, 0);
    checks++;
    if (err_cnt - e0 !== 1 || e !== 1) begin
      failures++;
      $display("FAIL bad_idx_err got %0d want 1", err_cnt - e0);
    end
    frame_pulse();
    model_commit();
    @(posedge clk);
    #1;
    checks++;
    if ({sprite_x, sprite_y, sprite_color, sprite_en} !== exp_regs()) begin
      failures++;
      $display("FAIL bad_idx_regs got %h want %h",
        {sprite_x, sprite_y, sprite_color, sprite_en}, exp_regs());
    end
  endtask

  task automatic test_pos_abort();
    bq_t q = '{8'h02, 8'h03, 8'hFF};
    int e, e0;
    e0 = err_cnt;
    model_txn(q, e);
    send_txn(q, 0);
    checks++;
    if (err_cnt - e0 !== 1 || e !== 1) begin
      failures++;
      $display("FAIL abort_err got %0d want 1", err_cnt - e0);
    end
    frame_pulse();
    model_commit();
    @(posedge clk);
    #1;
    checks++;
    if ({sprite_x, sprite_y, sprite_color, sprite_en} !== exp_regs()) begin
      failures++;
      $display("FAIL abort_regs got %h want %h",
        {sprite_x, sprite_y, sprite_color, sprite_en}, exp_regs());
    end
  endtask

  task automatic test_enable_pending();
    bq_t q1 = '{8'hC2, 8'h01};
    bq_t q2 = '{8'h43, 8'h2A};
    int e;
    model_txn(q1, e);
    send_txn(q1, 0);
    model_txn(q2, e);
    @(negedge clk);
    spi_cs_n = 1'b0;
    repeat (4) @(negedge clk);
    spi_bits(q2[0], 8);
    frame_pulse();
    spi_bits(q2[1], 8);
    repeat (6) @(negedge clk);
    checks++;
    if (sprite_en !== 4'b0000) begin
      failures++;
      $display("FAIL pend_hold got %b want 0000", sprite_en);
    end
    spi_cs_n = 1'b1;
    model_commit();
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (sprite_en !== 4'b0100) begin
      failures++;
      $display("FAIL pend_en got %b want 0100", sprite_en);
    end
    checks++;
    if ({sprite_x, sprite_y, sprite_color, sprite_en} !== exp_regs()) begin
      failures++;
      $display("FAIL pend_regs got %h want %h",
        {sprite_x, sprite_y, sprite_color, sprite_en}, exp_regs());
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_random();
    for (int it = 0; it < 20; it++) begin
      bq_t q;
      int e, e0, nd, op, idx;
      op = int'($urandom_range(0, 3));
      idx = ($urandom_range(0, 9) == 0) ? int'($urandom_range(4, 63))
                                        : int'($urandom_range(0, 3));
      case (op)
        0: nd = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 6)) : 4;
        2: nd = int'($urandom_range(0, NB + 2));
        default: nd = int'($urandom_range(0, 2));
      endcase
      q.push_back(8'((op << 6) | idx));
      for (int k = 0; k < nd; k++) q.push_back(8'($urandom));
      e0 = err_cnt;
      model_txn(q, e);
      send_txn(q, ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 7)) : 0);
      checks++;
      if (err_cnt - e0 !== e) begin
        failures++;
        $display("FAIL rnd%0d_err got %0d want %0d", it, err_cnt - e0, e);
      end
      frame_pulse();
      model_commit();
      @(posedge clk);
      #1;
      checks++;
      if ({sprite_x, sprite_y, sprite_color, sprite_en} !== exp_regs()) begin
        failures++;
        $display("FAIL rnd%0d_regs got %h want %h", it,
          {sprite_x, sprite_y, sprite_color, sprite_en}, exp_regs());
      end
      checks++;
      if (sprite_bitmap !== exp_bmp()) begin
        failures++;
        $display("FAIL rnd%0d_bmp sprite %0d got %h want %h", it,
          first_bad_bmp(), sprite_bitmap[first_bad_bmp()*BB +: BB],
          ab[first_bad_bmp()]);
      end
    end
  endtask

  task automatic test_reset_mid();
    bq_t q = '{8'h03, 8'h02, 8'hBC, 8'h13, 8'h57};
    int e, e0;
    @(negedge clk);
    spi_cs_n = 1'b0;
    repeat (4) @(negedge clk);
    spi_bits(8'h81, 8);
    spi_bits(8'hF0, 3);
    reset_n = 1'b0;
    model_clear();
    #1;
    checks++;
    if ({sprite_x, sprite_y, sprite_color, sprite_en} !== exp_regs()) begin
      failures++;
      $display("FAIL rmid_regs got %h want %h",
        {sprite_x, sprite_y, sprite_color, sprite_en}, exp_regs());
    end
    checks++;
    if (sprite_bitmap !== exp_bmp() || busy !== 1'b0) begin
      failures++;
      $display("FAIL rmid_bmp_busy busy %b sprite %0d got %h want %h", busy,
        first_bad_bmp(), sprite_bitmap[first_bad_bmp()*BB +: BB],
        ab[first_bad_bmp()]);
    end
    spi_data = 1'b0;
    spi_cs_n = 1'b1;
    repeat (4) @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    e0 = err_cnt;
    model_txn(q, e);
    send_txn(q, 0);
    frame_pulse();
    model_commit();
    @(posedge clk);
    #1;
    checks++;
    if (err_cnt - e0 !== e) begin
      failures++;
      $display("FAIL rmid_err got %0d want %0d", err_cnt - e0, e);
    end
    checks++;
    if ({sprite_x, sprite_y, sprite_color, sprite_en} !== exp_regs()) begin
      failures++;
      $display("FAIL rmid_after got %h want %h",
        {sprite_x, sprite_y, sprite_color, sprite_en}, exp_regs());
    end
  endtask

  initial begin
    reset_n = 1'b0;
    spi_clk = 1'b0;
    spi_data = 1'b0;
    spi_cs_n = 1'b1;
    next_frame = 1'b0;
    model_clear();
    test_reset();
    test_pos();
    test_bitmap();
    test_bad_index();
    test_pos_abort();
    test_enable_pending();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
